// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, frame width
// and line-level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_LINE_IDLE = 1'b1;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin search: grants the first requester at or after ptr,
// wrapping modulo NUM_REQ. The caller owns and advances the pointer.
module uart_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0] cand;

    // One extra bit on the candidate keeps the wrap correct for non-power-of-two counts.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (enable && !found && req[cand[IDX_W-1:0]]) begin
                found                     = 1'b1;
                grant[cand[IDX_W-1:0]]    = 1'b1;
                index                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter (8N1). Define UART_TX_PARITY_EN to insert
// an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int CLKS_PER_BIT = 16,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    input  logic [8*NUM_REQ-1:0]    req_data_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    output logic [IDX_W-1:0]        grant_id_out,
    output logic                    busy_out,
    output logic                    txd_out
);

    localparam int                 CNT_W         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int                 DIDX_W        = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]   BIT_LOAD      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(NUM_REQ - 1);
    localparam logic [DIDX_W-1:0]  LAST_DATA_BIT = DIDX_W'(UART_DATA_BITS - 1);

    uart_state_t                state;
    logic [CNT_W-1:0]           bit_cnt;
    logic [DIDX_W-1:0]          data_idx;
    logic [UART_DATA_BITS-1:0]  shift_reg;
    logic [IDX_W-1:0]           ptr;

    logic                       arb_enable;
    logic [NUM_REQ-1:0]         arb_grant;
    logic [IDX_W-1:0]           arb_index;
    logic                       arb_found;
    logic [UART_DATA_BITS-1:0]  req_bytes [NUM_REQ];

`ifdef UART_TX_PARITY_EN
    logic                       parity_bit;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data_in[UART_DATA_BITS*g +: UART_DATA_BITS];
    end

    // Ready must coincide with the cycle the byte is latched, so it is decoded
    // from the registered IDLE state; holding reset suppresses it entirely.
    assign arb_enable    = (state == UART_IDLE) && !rst_in;
    assign req_ready_out = arb_grant;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .enable (arb_enable),
        .req    (req_valid_in),
        .ptr    (ptr),
        .grant  (arb_grant),
        .index  (arb_index),
        .found  (arb_found)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= UART_IDLE;
            bit_cnt      <= '0;
            data_idx     <= '0;
            shift_reg    <= '0;
            ptr          <= '0;
            grant_id_out <= '0;
            busy_out     <= 1'b0;
            txd_out      <= UART_LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                UART_IDLE: begin
                    txd_out  <= UART_LINE_IDLE;
                    busy_out <= 1'b0;
                    bit_cnt  <= '0;
                    if (arb_found) begin
                        state        <= UART_START;
                        bit_cnt      <= BIT_LOAD;
                        shift_reg    <= req_bytes[arb_index];
                        grant_id_out <= arb_index;
                        ptr          <= (arb_index == LAST_IDX) ? '0 : arb_index + IDX_W'(1);
                        txd_out      <= UART_START_BIT;
                        busy_out     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_bit   <= uart_even_parity(req_bytes[arb_index]);
`endif
                    end
                end

                UART_START: begin
                    if (bit_cnt == '0) begin
                        state    <= UART_DATA;
                        bit_cnt  <= BIT_LOAD;
                        data_idx <= '0;
                        txd_out  <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

                // The line always shows shift_reg[0]; the next bit is pre-read from [1].
                UART_DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt   <= BIT_LOAD;
                        shift_reg <= shift_reg >> 1;
                        if (data_idx == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state   <= UART_PARITY;
                            txd_out <= parity_bit;
`else
                            state   <= UART_STOP;
                            txd_out <= UART_STOP_BIT;
`endif
                        end else begin
                            data_idx <= data_idx + DIDX_W'(1);
                            txd_out  <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                UART_PARITY: begin
                    if (bit_cnt == '0) begin
                        state   <= UART_STOP;
                        bit_cnt <= BIT_LOAD;
                        txd_out <= UART_STOP_BIT;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
`endif

                UART_STOP: begin
                    if (bit_cnt == '0) begin
                        state    <= UART_IDLE;
                        busy_out <= 1'b0;
                        txd_out  <= UART_LINE_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state    <= UART_IDLE;
                    bit_cnt  <= '0;
                    busy_out <= 1'b0;
                    txd_out  <= UART_LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one RS232 serial transmit line between several byte producers. Round-robin arbitration picks one pending requester per frame, latches its byte through a valid/ready handshake, and serialises it as 8N1 (start, 8 data LSB-first, stop) at a fixed clock-to-bit ratio. Sits between the on-chip byte sources and the `txd_out` pad, in front of the shared serial line.

## Interface
- `NUM_REQ`, 4: number of requesters; legal values are 2 and above.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal values are 2 and above.
- `clk_in`  in  1: single system clock; all logic is on its rising edge.
- `rst_in`  in  1: reset, asynchronous, active-high.
- `req_valid_in`  in  NUM_REQ: bit k set means requester k has a byte pending.
- `req_data_in`  in  8*NUM_REQ: byte for requester k at bits [8k+7:8k].
- `req_ready_out`  out  NUM_REQ: one-hot, one-cycle pulse; the byte is accepted on that cycle.
- `grant_id_out`  out  max(1,$clog2(NUM_REQ)): index of the requester currently or last served.
- `busy_out`  out  1: high while a frame is on the line.
- `txd_out`  out  1: serial output; idle level is 1.

## Operation
- FSM states:
  - IDLE → START when any `req_valid_in` bit is set.
  - START → DATA.
  - DATA (8 bits) → PARITY if enabled, else → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Every non-IDLE state holds `txd_out` for exactly `CLKS_PER_BIT` cycles, counted by a bit counter that loads `CLKS_PER_BIT-1` and counts down to 0.
- Arbitration happens only in IDLE.
  - Search order starts at `ptr` and wraps modulo `NUM_REQ`.
  - The first requester found with valid set is granted.
  - On the grant cycle, that requester's `req_ready_out` bit pulses, its byte is latched into the shift register, `grant_id_out` takes its index, and `ptr` becomes (index+1) mod `NUM_REQ`.
- Requesters must hold their data stable while valid is high until ready is seen. Dropping valid before the grant is legal and results in no transfer.
- `req_ready_out` is never asserted outside IDLE. Valid bits seen during a frame are ignored until the next IDLE cycle.
- Data bits go out LSB first, with the shift register shifting right at the end of each data bit.
- If only one requester is active, it is still served on every frame; the pointer moving does not starve it.
- Reset values:
  - `txd_out` = 1
  - `req_ready_out` = 0
  - `busy_out` = 0
  - `grant_id_out` = 0
  - `ptr` = 0
  - FSM = IDLE
  - bit counter = 0
- Reset asserted mid-frame aborts the frame immediately: `txd_out` returns to 1 asynchronously and the byte is discarded, never resumed.

## Timing
- Grant at cycle t (IDLE with any valid set): `req_ready_out` is high during cycle t only.
- All outputs are registered. `txd_out` falls at t+1.
- Line schedule:
  - Start bit: cycles t+1 … t+C (C = `CLKS_PER_BIT`).
  - Data bit i: t+1+(i+1)C … t+(i+2)C.
  - Stop bit: t+1+9C … t+10C.
- `busy_out` is high from t+1 through t+10C inclusive. With parity enabled, the stop bit shifts by C and busy ends at t+11C.
- The FSM returns to IDLE at t+10C+1, which is also the earliest next grant cycle. The next start bit therefore begins at t+10C+2, leaving exactly one idle-high cycle between back-to-back frames.
- Frame period is 10C+1 cycles without parity, 11C+1 with parity.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - The parity bit is the XOR of the 8 data bits (even parity), held for C cycles.
- `UART_TX_PARITY_EN` undefined:
  - No parity state and no parity logic; 8N1 framing only.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state typedef (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`)
  - `UART_DATA_BITS` = 8
  - idle line level constant (1)
  - start/stop bit constants
- Sub-module `uart_rr_arbiter` (parameter `NUM_REQ`):
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant, index, found flag
  - combinational search, with pointer update in the parent
- The top level owns the FSM, bit counter, data-bit index, and shift register.

## Test plan
- Reset, then requester 0 with byte 0x55, C=4 → `req_ready_out`=0001 for one cycle; `txd_out` sequence per 4-cycle bit is 0,1,0,1,0,1,0,1,0,1; `busy_out` high for 40 cycles.
- Requesters 0-3 all valid and held, bytes 0xA0-0xA3 → served in order 0,1,2,3,0; one idle-high cycle between frames; `grant_id_out` follows 0,1,2,3.
- Requester 2 only, continuously valid with 0xFF → back-to-back frames every 10C+1 cycles; `grant_id_out`=2 on every frame.
- Valid raised on requester 1 mid-frame for requester 3 → no ready pulse until the IDLE cycle after the stop bit, then requester 1 is granted.
- Reset pulsed during data bit 4 → `txd_out`=1 and `busy_out`=0 immediately; the next grant goes to requester 0 and a full new frame follows.
- With `UART_TX_PARITY_EN` defined, byte 0x07 → parity bit 1 after data bit 7; frame is 11C cycles.
